// File: rtl/opb_sw_reg_bank_ctrl_if.sv
// OPB slave bus and downstream config handshake for opb_sw_reg_bank_ctrl.
// The bus side keeps the IBM big-endian [0:31] numbering; bit 0 is the MSB.
interface opb_sw_reg_bank_ctrl_if;
   logic [0:31]  OPB_ABus;
   logic [0:3]   OPB_BE;
   logic [0:31]  OPB_DBus;
   logic         OPB_RNW;
   logic         OPB_select;
   logic         OPB_seqAddr;
   logic [0:31]  Sl_DBus;
   logic         Sl_xferAck;
   logic         Sl_errAck;
   logic         Sl_retry;
   logic         Sl_toutSup;
   logic [127:0] cfg_data;
   logic         cfg_valid;
   logic         cfg_ready;

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr, cfg_ready,
      input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, cfg_data, cfg_valid
   );

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr, cfg_ready,
      output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, cfg_data, cfg_valid
   );
endinterface

// File: rtl/opb_sw_reg_bank_ctrl.sv
// OPB slave holding four shadow config words plus a CTRL register. A commit
// copies all shadow words into the active config at once and offers it
// downstream through a valid/ready handshake.
module opb_sw_reg_bank_ctrl #(
   parameter logic [31:0] C_BASEADDR = 32'h01000400,
   parameter logic [31:0] C_HIGHADDR = 32'h010004FF
) (
   input  logic                  OPB_Clk,
   input  logic                  OPB_Rst,
   opb_sw_reg_bank_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACK, S_TURN} state_t;

   localparam logic [5:0] CTRL_WORD = 6'd4;

   state_t       state_q;
   logic [5:0]   word_q;
   logic [31:0]  wdata_q;
   logic [0:3]   be_q;
   logic         rnw_q;
   logic [31:0]  rdata_q;
   logic [31:0]  shadow_q [4];
   logic [127:0] active_q;
   logic         cfg_valid_q;
   logic [7:0]   count_q;

   logic [31:0]  abus;
   logic [31:0]  addr_off;
   logic [5:0]   word;
   logic         hit;
   logic [31:0]  rdata_d;
   logic [31:0]  wmerge_d;
   logic         in_ack;
   logic         commit_req;
   logic         handshake;
   logic         commit_ok;
   logic         cfg_valid_d;
   logic [7:0]   count_d;
   logic [127:0] active_d;
   logic         unused_sink;

   // Numeric value is unchanged by the [0:31] -> [31:0] copy; ABus[24:29] is addr_off[7:2].
   assign abus     = bus.OPB_ABus;
   assign addr_off = abus - C_BASEADDR;
   assign word     = addr_off[7:2];
   assign hit      = bus.OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
   assign in_ack   = (state_q == S_ACK);

   assign unused_sink = ^{bus.OPB_seqAddr, addr_off[31:8], addr_off[1:0]};

   // Read mux for the address presented in the hit cycle; unmapped words read 0.
   always_comb begin
      rdata_d = '0;
      if (word < 6'd4) begin
         rdata_d = shadow_q[word[1:0]];
      end else if (word == CTRL_WORD) begin
         rdata_d[0]    = cfg_valid_q;   // DBus[31]: pending
         rdata_d[15:8] = count_q;       // DBus[16:23]: commit count
      end
   end

   // Byte-lane merge of captured write data; BE[b] covers DBus[8b:8b+7].
   always_comb begin
      wmerge_d = shadow_q[word_q[1:0]];
      for (int unsigned b = 0; b < 4; b++) begin
         if (be_q[b]) begin
            wmerge_d[8*(3-b) +: 8] = wdata_q[8*(3-b) +: 8];
         end
      end
   end

   // Commit arbitration; a handshake completing in the commit cycle frees the slot.
   always_comb begin
      commit_req  = in_ack && !rnw_q && (word_q == CTRL_WORD) && be_q[3] && wdata_q[0];
      handshake   = cfg_valid_q && bus.cfg_ready;
      commit_ok   = commit_req && (!cfg_valid_q || handshake);
      cfg_valid_d = cfg_valid_q;
      if (handshake) begin
         cfg_valid_d = 1'b0;
      end
      if (commit_ok) begin
         cfg_valid_d = 1'b1;
      end
      active_d = commit_ok ? {shadow_q[3], shadow_q[2], shadow_q[1], shadow_q[0]} : active_q;
      count_d  = commit_ok ? count_q + 8'd1 : count_q;
   end

   // Slave FSM: capture the transfer on a hit, then ACK and one turnaround cycle.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rnw_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (hit) begin
                  state_q <= S_ACK;
                  word_q  <= word;
                  wdata_q <= bus.OPB_DBus;
                  be_q    <= bus.OPB_BE;
                  rnw_q   <= bus.OPB_RNW;
                  rdata_q <= rdata_d;
               end
            end
            S_ACK:   state_q <= S_TURN;
            S_TURN:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Register bank: shadow writes and commits both land on the edge closing ACK.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         for (int unsigned i = 0; i < 4; i++) begin
            shadow_q[i] <= '0;
         end
         active_q    <= '0;
         cfg_valid_q <= 1'b0;
         count_q     <= '0;
      end else begin
         if (in_ack && !rnw_q && (word_q < 6'd4)) begin
            shadow_q[word_q[1:0]] <= wmerge_d;
         end
         active_q    <= active_d;
         cfg_valid_q <= cfg_valid_d;
         count_q     <= count_d;
      end
   end

   // Reset in the ACK cycle suppresses the acknowledge and read data immediately.
   assign bus.Sl_xferAck = in_ack && !OPB_Rst;
   assign bus.Sl_errAck  = commit_req && !commit_ok && !OPB_Rst;
   assign bus.Sl_DBus    = (in_ack && rnw_q && !OPB_Rst) ? rdata_q : '0;
   assign bus.Sl_retry   = 1'b0;
   assign bus.Sl_toutSup = 1'b0;
   assign bus.cfg_data   = active_q;
   assign bus.cfg_valid  = cfg_valid_q;
endmodule

// File: tb/tb_opb_sw_reg_bank_ctrl.sv
// Directed bench for opb_sw_reg_bank_ctrl: register access, commit/handshake,
// commit counter wrap, reset mid-transfer and address window decode.
module tb_opb_sw_reg_bank_ctrl;
   logic OPB_Clk;
   logic OPB_Rst;
   int   n_cmp;
   int   n_err;

   opb_sw_reg_bank_ctrl_if bus ();

   opb_sw_reg_bank_ctrl #(
      .C_BASEADDR (32'h01000400),
      .C_HIGHADDR (32'h010004FF)
   ) dut (
      .OPB_Clk (OPB_Clk),
      .OPB_Rst (OPB_Rst),
      .bus     (bus)
   );

   initial OPB_Clk = 1'b0;
   always #5 OPB_Clk = ~OPB_Clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One OPB transfer; gives up after 8 cycles without an acknowledge.
   task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] data,
                       input logic [3:0] be, input bit rdy_in_ack,
                       output bit acked, output int lat, output logic [31:0] rd,
                       output bit err, output bit ack_after);
      acked = 1'b0; lat = 0; rd = '0; err = 1'b0; ack_after = 1'b0;
      bus.OPB_ABus   = addr;
      bus.OPB_RNW    = rnw;
      bus.OPB_DBus   = data;
      bus.OPB_BE     = be;
      bus.OPB_select = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge OPB_Clk); #1;
         if (bus.Sl_xferAck) begin
            acked = 1'b1;
            lat   = i;
            if (rdy_in_ack) begin
               bus.cfg_ready = 1'b1;
               #1;
            end
            rd  = bus.Sl_DBus;
            err = bus.Sl_errAck;
            break;
         end
      end
      bus.OPB_select = 1'b0;
      if (acked) begin
         @(posedge OPB_Clk); #1;
         ack_after = bus.Sl_xferAck;
         if (rdy_in_ack) bus.cfg_ready = 1'b0;
         @(posedge OPB_Clk); #1;
      end
   endtask

   initial begin
      bit          acked, err, ack_after;
      int          lat, nacks, errsum;
      logic [31:0] rd;
      logic [127:0] cfg_exp;

      n_cmp = 0;
      n_err = 0;
      OPB_Rst         = 1'b1;
      bus.OPB_ABus    = '0;
      bus.OPB_BE      = '0;
      bus.OPB_DBus    = '0;
      bus.OPB_RNW     = 1'b0;
      bus.OPB_select  = 1'b0;
      bus.OPB_seqAddr = 1'b0;
      bus.cfg_ready   = 1'b0;

      // Reset state
      repeat (3) @(posedge OPB_Clk);
      #1;
      chk("rst_dbus", bus.Sl_DBus, 0);
      chk("rst_xferack", bus.Sl_xferAck, 0);
      chk("rst_errack", bus.Sl_errAck, 0);
      chk("rst_retry", bus.Sl_retry, 0);
      chk("rst_toutsup", bus.Sl_toutSup, 0);
      chk("rst_cfg_valid", bus.cfg_valid, 0);
      chk("rst_cfg_data", bus.cfg_data, 0);
      OPB_Rst = 1'b0;
      @(posedge OPB_Clk); #1;

      // Full-word write and readback
      xfer(32'h01000400, 1'b0, 32'hDEADBEEF, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("wr0_ack", acked, 1);
      chk("wr0_latency", lat, 1);
      chk("wr0_single_ack", ack_after, 0);
      chk("wr0_dbus_zero", rd, 0);
      chk("wr0_err", err, 0);
      xfer(32'h01000400, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("rd0_data", rd, 32'hDEADBEEF);
      chk("rd0_latency", lat, 1);
      chk("cfg_untouched", bus.cfg_data, 0);
      chk("dbus_idle_zero", bus.Sl_DBus, 0);

      // Byte-enable merge
      xfer(32'h01000404, 1'b0, 32'h11223344, 4'b0101, 1'b0, acked, lat, rd, err, ack_after);
      xfer(32'h01000404, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("rd1_be_merge", rd, 32'h00220044);

      // Select held high: acks at most every third cycle
      nacks = 0;
      bus.OPB_ABus   = 32'h01000400;
      bus.OPB_RNW    = 1'b1;
      bus.OPB_BE     = 4'b1111;
      bus.OPB_select = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge OPB_Clk); #1;
         if (bus.Sl_xferAck) nacks++;
      end
      bus.OPB_select = 1'b0;
      chk("ack_spacing", nacks, 3);
      repeat (3) @(posedge OPB_Clk);
      #1;

      // First commit, downstream not ready
      xfer(32'h0100040C, 1'b0, 32'hA5A5A5A5, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      xfer(32'h01000410, 1'b0, 32'h00000001, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("commit1_err", err, 0);
      chk("commit1_valid", bus.cfg_valid, 1);
      cfg_exp = {32'hA5A5A5A5, 32'h00000000, 32'h00220044, 32'hDEADBEEF};
      chk("commit1_data", bus.cfg_data, cfg_exp);
      xfer(32'h01000410, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("ctrl_pend_cnt1", rd, 32'h00000101);

      // Shadow write while pending leaves cfg_data alone
      xfer(32'h01000408, 1'b0, 32'h12345678, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("pending_shadow_wr", bus.cfg_data, cfg_exp);

      // CTRL writes that are not commit requests
      xfer(32'h01000410, 1'b0, 32'hFFFFFFFE, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("ctrl_bit31_clear_err", err, 0);
      xfer(32'h01000410, 1'b0, 32'h00000001, 4'b1110, 1'b0, acked, lat, rd, err, ack_after);
      chk("ctrl_be3_clear_err", err, 0);

      // Commit while pending is rejected
      xfer(32'h01000410, 1'b0, 32'h00000001, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("reject_ack", acked, 1);
      chk("reject_err", err, 1);
      xfer(32'h01000410, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("reject_cnt", rd, 32'h00000101);
      chk("reject_data", bus.cfg_data, cfg_exp);

      // Handshake clears valid next cycle
      bus.cfg_ready = 1'b1;
      @(posedge OPB_Clk); #1;
      chk("hs_valid_clear", bus.cfg_valid, 0);
      chk("hs_data_stable", bus.cfg_data, cfg_exp);
      repeat (3) @(posedge OPB_Clk);
      #1;
      chk("ready_idle_ignored", bus.cfg_valid, 0);
      bus.cfg_ready = 1'b0;

      // Non-commit CTRL writes while idle
      xfer(32'h01000410, 1'b0, 32'hFFFFFFFE, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      xfer(32'h01000410, 1'b0, 32'h00000001, 4'b1110, 1'b0, acked, lat, rd, err, ack_after);
      chk("noncommit_valid", bus.cfg_valid, 0);
      xfer(32'h01000410, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("ctrl_idle_cnt1", rd, 32'h00000100);

      // Second commit picks up the new shadow[2]
      xfer(32'h01000410, 1'b0, 32'h00000001, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      cfg_exp = {32'hA5A5A5A5, 32'h12345678, 32'h00220044, 32'hDEADBEEF};
      chk("commit2_data", bus.cfg_data, cfg_exp);
      chk("commit2_valid", bus.cfg_valid, 1);

      // Commit in the same cycle the handshake completes is accepted
      xfer(32'h01000400, 1'b0, 32'hCAFEF00D, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      xfer(32'h01000410, 1'b0, 32'h00000001, 4'b1111, 1'b1, acked, lat, rd, err, ack_after);
      chk("samecycle_err", err, 0);
      chk("samecycle_valid", bus.cfg_valid, 1);
      chk("samecycle_data0", bus.cfg_data[31:0], 32'hCAFEF00D);
      xfer(32'h01000410, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("ctrl_cnt3", rd, 32'h00000301);

      // Counter wrap: 253 more commits makes 256
      bus.cfg_ready = 1'b1;
      errsum = 0;
      for (int i = 0; i < 253; i++) begin
         xfer(32'h01000410, 1'b0, 32'h00000001, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
         if (err || !acked) errsum++;
      end
      chk("wrap_loop_errs", errsum, 0);
      xfer(32'h01000410, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("ctrl_cnt_wrap", rd, 32'h00000000);
      bus.cfg_ready = 1'b0;

      // Reset asserted during the ACK cycle of a write
      bus.OPB_ABus   = 32'h0100040C;
      bus.OPB_RNW    = 1'b0;
      bus.OPB_DBus   = 32'h77777777;
      bus.OPB_BE     = 4'b1111;
      bus.OPB_select = 1'b1;
      @(posedge OPB_Clk); #1;
      OPB_Rst = 1'b1;
      #1;
      chk("rst_in_ack_noack", bus.Sl_xferAck, 0);
      bus.OPB_select = 1'b0;
      @(posedge OPB_Clk); #1;
      chk("postrst_dbus", bus.Sl_DBus, 0);
      chk("postrst_ack", bus.Sl_xferAck, 0);
      chk("postrst_err", bus.Sl_errAck, 0);
      chk("postrst_retry", bus.Sl_retry, 0);
      chk("postrst_cfg_data", bus.cfg_data, 0);
      chk("postrst_valid", bus.cfg_valid, 0);
      @(posedge OPB_Clk); #1;
      OPB_Rst = 1'b0;
      @(posedge OPB_Clk); #1;
      xfer(32'h0100040C, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("postrst_shadow3", rd, 0);
      xfer(32'h01000410, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("postrst_ctrl", rd, 0);

      // Address window decode
      xfer(32'h01000500, 1'b0, 32'hFFFFFFFF, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("above_window_noack", acked, 0);
      xfer(32'h010003FC, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("below_window_noack", acked, 0);
      xfer(32'h01000420, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("unmapped_ack", acked, 1);
      chk("unmapped_rd", rd, 0);
      xfer(32'h01000400, 1'b0, 32'h13579BDF, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      xfer(32'h01000420, 1'b0, 32'hFFFFFFFF, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      xfer(32'h01000403, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("no_alias_byteoff", rd, 32'h13579BDF);
      xfer(32'h010004FF, 1'b1, 32'h0, 4'b1111, 1'b0, acked, lat, rd, err, ack_after);
      chk("top_edge_ack", acked, 1);
      chk("top_edge_rd", rd, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
